// File: rtl/axil_cfg_master.sv
// axil_cfg_master: AXI4-Lite initiator. Turns one command beat into exactly
// one AXI-Lite read or write, then returns one response beat. Only one
// transaction is ever in flight, and every output comes straight from a flop.
//
// Handshake semantics (cmd, rsp and all AXI channels): a beat transfers on a
// rising edge where valid & ready are both high. A source never waits for
// ready before raising valid. Once valid is high it stays high, with its
// payload stable, until the transfer completes.
module axil_cfg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                        m_axi_ps_clk,
  input  logic                                        m_axi_ps_aresetn,
  input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8-1:0] cmd_tdata,
  input  logic                                        cmd_tuser,
  input  logic                                        cmd_tvalid,
  output logic                                        cmd_tready,
  output logic [DATA_WIDTH-1:0]                       rsp_tdata,
  output logic [2:0]                                  rsp_tuser,
  output logic                                        rsp_tvalid,
  input  logic                                        rsp_tready,
  output logic [ADDR_WIDTH-1:0]                       m_axi_ps_awaddr,
  output logic [2:0]                                  m_axi_ps_awprot,
  output logic                                        m_axi_ps_awvalid,
  input  logic                                        m_axi_ps_awready,
  output logic [DATA_WIDTH-1:0]                       m_axi_ps_wdata,
  output logic [DATA_WIDTH/8-1:0]                     m_axi_ps_wstrb,
  output logic                                        m_axi_ps_wvalid,
  input  logic                                        m_axi_ps_wready,
  input  logic [1:0]                                  m_axi_ps_bresp,
  input  logic                                        m_axi_ps_bvalid,
  output logic                                        m_axi_ps_bready,
  output logic [ADDR_WIDTH-1:0]                       m_axi_ps_araddr,
  output logic [2:0]                                  m_axi_ps_arprot,
  output logic                                        m_axi_ps_arvalid,
  input  logic                                        m_axi_ps_arready,
  input  logic [DATA_WIDTH-1:0]                       m_axi_ps_rdata,
  input  logic [1:0]                                  m_axi_ps_rresp,
  input  logic                                        m_axi_ps_rvalid,
  output logic                                        m_axi_ps_rready,
  output logic                                        timeout,
  output logic [15:0]                                 err_count,
  output logic [2:0]                                  dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WR_B  = 3'd2,
    S_RD_AR = 3'd3,
    S_RD_R  = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_tready_q, cmd_tready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_tvalid_q, rsp_tvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    is_read_q, is_read_d;
  logic [15:0]             wait_cnt_q, wait_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             err_count_q, err_count_d;

  // Command word layout: {wstrb, addr, wdata}, wdata in the LSBs.
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [STRB_WIDTH-1:0]   cmd_wstrb;
  assign cmd_wdata = cmd_tdata[DATA_WIDTH-1:0];
  assign cmd_addr  = cmd_tdata[DATA_WIDTH +: ADDR_WIDTH];
  assign cmd_wstrb = cmd_tdata[DATA_WIDTH+ADDR_WIDTH +: STRB_WIDTH];

  logic waiting;
  assign waiting = (state_q == S_WR) || (state_q == S_WR_B) ||
                   (state_q == S_RD_AR) || (state_q == S_RD_R);

  // Next-state, channel control, capture, and timeout/error bookkeeping.
  always_comb begin
    state_d      = state_q;
    cmd_tready_d = cmd_tready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rsp_tvalid_d = rsp_tvalid_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    araddr_d     = araddr_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    is_read_d    = is_read_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    err_count_d  = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_tvalid && cmd_tready_q) begin
          cmd_tready_d = 1'b0;
          is_read_d    = cmd_tuser;
          if (cmd_tuser) begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end else begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end
        end else begin
          cmd_tready_d = 1'b1;
        end
      end
      S_WR: begin
        // AW and W retire independently; move on once neither is pending.
        if (awvalid_q && m_axi_ps_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_ps_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_ps_awready) && (!wvalid_q || m_axi_ps_wready)) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (m_axi_ps_bvalid && bready_q) begin
          resp_d       = m_axi_ps_bresp;
          rdata_d      = '0;
          bready_d     = 1'b0;
          rsp_tvalid_d = 1'b1;
          state_d      = S_RSP;
        end
      end
      S_RD_AR: begin
        if (arvalid_q && m_axi_ps_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (m_axi_ps_rvalid && rready_q) begin
          rdata_d      = m_axi_ps_rdata;
          resp_d       = m_axi_ps_rresp;
          rready_d     = 1'b0;
          rsp_tvalid_d = 1'b1;
          state_d      = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_tready) begin
          rsp_tvalid_d = 1'b0;
          cmd_tready_d = 1'b1;
          state_d      = S_IDLE;
          if ((resp_q != 2'b00) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The wait counter only tracks the current handshake wait; the
    // transaction itself keeps going after the timeout flag sets.
    if (waiting) begin
      if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
      if (({1'b0, wait_cnt_q} + 17'd1) >= TO_LIMIT) timeout_d = 1'b1;
    end
    if (state_d != state_q) wait_cnt_d = '0;
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge m_axi_ps_clk or negedge m_axi_ps_aresetn) begin
    if (!m_axi_ps_aresetn) begin
      state_q      <= S_IDLE;
      cmd_tready_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_tvalid_q <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      araddr_q     <= '0;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
      is_read_q    <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_tready_q <= cmd_tready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rsp_tvalid_q <= rsp_tvalid_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      araddr_q     <= araddr_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      is_read_q    <= is_read_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      err_count_q  <= err_count_d;
    end
  end

  assign cmd_tready       = cmd_tready_q;
  assign rsp_tdata        = rdata_q;
  assign rsp_tuser        = {is_read_q, resp_q};
  assign rsp_tvalid       = rsp_tvalid_q;
  assign m_axi_ps_awaddr  = awaddr_q;
  assign m_axi_ps_awprot  = 3'b000;
  assign m_axi_ps_awvalid = awvalid_q;
  assign m_axi_ps_wdata   = wdata_q;
  assign m_axi_ps_wstrb   = wstrb_q;
  assign m_axi_ps_wvalid  = wvalid_q;
  assign m_axi_ps_bready  = bready_q;
  assign m_axi_ps_araddr  = araddr_q;
  assign m_axi_ps_arprot  = 3'b000;
  assign m_axi_ps_arvalid = arvalid_q;
  assign m_axi_ps_rready  = rready_q;
  assign timeout          = timeout_q;
  assign err_count        = err_count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb_axil_cfg_master: drives command/response streams and acts as an AXI-Lite
// slave with per-transaction delays. Expected cycle timing is derived from the
// handshake rules: each phase ends on the first cycle its ready/valid meet.
module tb_axil_cfg_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic [67:0]   cmd_tdata;
  logic          cmd_tuser, cmd_tvalid, cmd_tready;
  logic [31:0]   rsp_tdata;
  logic [2:0]    rsp_tuser;
  logic          rsp_tvalid, rsp_tready;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [2:0]    awprot, arprot, dbg_state;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic          timeout;
  logic [15:0]   err_count;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_err = 0;
  logic          exp_timeout = 0;

  axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_ps_clk(clk), .m_axi_ps_aresetn(rst_n),
    .cmd_tdata(cmd_tdata), .cmd_tuser(cmd_tuser), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .rsp_tdata(rsp_tdata), .rsp_tuser(rsp_tuser), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .m_axi_ps_awaddr(awaddr), .m_axi_ps_awprot(awprot), .m_axi_ps_awvalid(awvalid), .m_axi_ps_awready(awready),
    .m_axi_ps_wdata(wdata), .m_axi_ps_wstrb(wstrb), .m_axi_ps_wvalid(wvalid), .m_axi_ps_wready(wready),
    .m_axi_ps_bresp(bresp), .m_axi_ps_bvalid(bvalid), .m_axi_ps_bready(bready),
    .m_axi_ps_araddr(araddr), .m_axi_ps_arprot(arprot), .m_axi_ps_arvalid(arvalid), .m_axi_ps_arready(arready),
    .m_axi_ps_rdata(rdata), .m_axi_ps_rresp(rresp), .m_axi_ps_rvalid(rvalid), .m_axi_ps_rready(rready),
    .timeout(timeout), .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          d0;       // aw (write) / ar (read) ready delay
    int          d1;       // w ready delay (write) / r valid delay (read)
    int          d2;       // b valid delay (write)
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          rsp_dly;  // rsp_tready delay after rsp_tvalid
    logic [31:0] exp_data;
    logic [2:0]  exp_user;
  } vec_t;

  function automatic vec_t mk(input logic is_rd, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] strb, input int d0, input int d1, input int d2,
                              input logic [1:0] resp, input logic [31:0] rd, input int rsp_dly,
                              input logic [31:0] exp_data, input logic [2:0] exp_user);
    vec_t v;
    v.is_rd = is_rd; v.addr = addr; v.wdata = wd; v.strb = strb;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.resp = resp; v.rdata = rd; v.rsp_dly = rsp_dly;
    v.exp_data = exp_data; v.exp_user = exp_user;
    return v;
  endfunction

  task automatic check(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    rsp_tready = 0;
  endtask

  // Expected timeout at cycle k: sticky, set once any wait phase [s,e]
  // has accumulated TO completed cycles.
  function automatic logic to_model(input logic prior, input int k, input int s1, input int e1,
                                    input int s2, input int e2);
    logic t = prior;
    int c;
    if (k >= s1) begin c = ((k < e1 + 1) ? k : e1 + 1) - s1; if (c >= TO) t = 1'b1; end
    if (k >= s2) begin c = ((k < e2 + 1) ? k : e2 + 1) - s2; if (c >= TO) t = 1'b1; end
    return t;
  endfunction

  // Drivers: issue one command, play the slave, check every cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int a_hs, w_hs, hs, b_cyc, rsp_first, rsp_hs, n;
    logic t_exp;
    a_hs = 1 + v.d0;
    if (v.is_rd) begin
      w_hs = 0; hs = a_hs; b_cyc = hs + 1 + v.d1;
    end else begin
      w_hs = 1 + v.d1; hs = (a_hs > w_hs) ? a_hs : w_hs; b_cyc = hs + 1 + v.d2;
    end
    rsp_first = b_cyc + 1;
    rsp_hs    = rsp_first + v.rsp_dly;
    t_exp     = exp_timeout;

    @(negedge clk);
    cmd_tdata  = {v.strb, v.addr, v.wdata};
    cmd_tuser  = v.is_rd;
    cmd_tvalid = 1'b1;
    n = 0;
    while (!cmd_tready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      check(tag, "cmd accept timeout", 64'd0, 64'd1);
      cmd_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_tvalid = 1'b0;

    for (int k = 1; k <= rsp_hs + 1; k++) begin
      check(tag, "cmd_tready", cmd_tready, k > rsp_hs);
      check(tag, "awvalid", awvalid, !v.is_rd && k <= a_hs);
      check(tag, "wvalid", wvalid, !v.is_rd && k <= w_hs);
      check(tag, "bready", bready, !v.is_rd && k > hs && k <= b_cyc);
      check(tag, "arvalid", arvalid, v.is_rd && k <= a_hs);
      check(tag, "rready", rready, v.is_rd && k > hs && k <= b_cyc);
      if (!v.is_rd && k <= a_hs) check(tag, "awaddr", awaddr, v.addr);
      if (!v.is_rd && k <= w_hs) check(tag, "wdata/wstrb", {wstrb, wdata}, {v.strb, v.wdata});
      if (v.is_rd && k <= a_hs)  check(tag, "araddr", araddr, v.addr);
      check(tag, "prot", {awprot, arprot}, 6'd0);
      check(tag, "rsp_tvalid", rsp_tvalid, k >= rsp_first && k <= rsp_hs);
      if (k >= rsp_first && k <= rsp_hs) begin
        check(tag, "rsp_tdata", rsp_tdata, v.exp_data);
        check(tag, "rsp_tuser", rsp_tuser, v.exp_user);
      end
      check(tag, "err_count", err_count, exp_err);
      t_exp = to_model(exp_timeout, k, 1, hs, hs + 1, b_cyc);
      check(tag, "timeout", timeout, t_exp);

      awready    = !v.is_rd && k >= a_hs;
      wready     = !v.is_rd && k >= w_hs;
      bvalid     = !v.is_rd && k == b_cyc;
      bresp      = (!v.is_rd && k == b_cyc) ? v.resp : 2'b00;
      arready    = v.is_rd && k >= a_hs;
      rvalid     = v.is_rd && k == b_cyc;
      rdata      = (v.is_rd && k == b_cyc) ? v.rdata : 32'h0;
      rresp      = (v.is_rd && k == b_cyc) ? v.resp : 2'b00;
      rsp_tready = (k >= rsp_hs);

      if (k == rsp_hs && v.resp != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      if (k <= rsp_hs) @(negedge clk);
    end
    exp_timeout = t_exp;
    slave_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, "valids/readies",
          {cmd_tready, rsp_tvalid, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check(tag, "addr/data", {awaddr, araddr}, 64'd0);
    check(tag, "wdata/wstrb", {wstrb, wdata}, 64'd0);
    check(tag, "rsp data/user", {rsp_tuser, rsp_tdata}, 64'd0);
    check(tag, "timeout/err", {timeout, err_count}, 64'd0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    rst_n = 0; cmd_tdata = '0; cmd_tuser = 0; cmd_tvalid = 0;
    slave_idle();

    tbl[0] = mk(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 3'b000);
    tbl[1] = mk(1, 32'h0000_0014, 32'h0, 4'h0, 3, 0, 0, 2'b00, 32'h1234_5678, 0, 32'h1234_5678, 3'b100);
    tbl[2] = mk(0, 32'h0000_0020, 32'hA5A5_0F0F, 4'h3, 0, 5, 0, 2'b00, 32'h0, 0, 32'h0, 3'b000);
    tbl[3] = mk(1, 32'h0000_0030, 32'h0, 4'h0, 0, 1, 0, 2'b10, 32'hCAFE_0001, 0, 32'hCAFE_0001, 3'b110);
    tbl[4] = mk(0, 32'h0000_0040, 32'h1111_2222, 4'hF, 1, 0, 2, 2'b11, 32'h0, 0, 32'h0, 3'b011);
    tbl[5] = mk(0, 32'h0000_0044, 32'h0BAD_F00D, 4'h5, 0, 0, 1, 2'b00, 32'h0, 3, 32'h0, 3'b000);

    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
    check("tbl", "err_count after errors", err_count, 16'd2);

    // Randomized traffic; delays stay well under the timeout limit.
    for (int i = 0; i < 40; i++) begin
      rv.is_rd   = 1'($urandom_range(0, 1));
      rv.addr    = $urandom & 32'hFFFF_FFFC;
      rv.wdata   = $urandom;
      rv.strb    = 4'($urandom_range(0, 15));
      rv.d0      = $urandom_range(0, 4);
      rv.d1      = $urandom_range(0, 4);
      rv.d2      = $urandom_range(0, 4);
      rv.resp    = 2'($urandom_range(0, 3));
      rv.rdata   = $urandom;
      rv.rsp_dly = $urandom_range(0, 3);
      rv.exp_data = rv.is_rd ? rv.rdata : 32'h0;
      rv.exp_user = {rv.is_rd, rv.resp};
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Slave holds off bvalid for 20 cycles: timeout sets, write still completes.
    rv = mk(0, 32'h0000_0100, 32'h5555_AAAA, 4'hF, 0, 0, 20, 2'b00, 32'h0, 0, 32'h0, 3'b000);
    run_txn(rv, "bstall");
    check("bstall", "timeout sticky", timeout, 1'b1);
    rv = mk(1, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h7777_8888, 1, 32'h7777_8888, 3'b100);
    run_txn(rv, "after_to");

    // Reset while arvalid is high and rsp_tready is low: transaction dropped.
    @(negedge clk);
    cmd_tdata = {4'h0, 32'h0000_0200, 32'h0}; cmd_tuser = 1; cmd_tvalid = 1;
    for (int n = 0; n < 50 && !cmd_tready; n++) @(negedge clk);
    @(negedge clk);
    cmd_tvalid = 0;
    @(negedge clk);
    check("midrst", "arvalid before reset", arvalid, 1'b1);
    rst_n = 0;
    #1;
    check_all_zero("midrst");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("midrst", "rsp_tvalid in reset", rsp_tvalid, 1'b0);
    end
    rst_n = 1;
    exp_err = 0;
    exp_timeout = 0;
    @(negedge clk);
    check("midrst", "rsp_tvalid after release", rsp_tvalid, 1'b0);
    run_txn(tbl[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
